byte_unstriping_n: RTL

Parametrised successor to the two-lane unstriper in the PHY receive path. It buffers NUM_LANES incoming lane words in per-lane FIFOs, which absorbs inter-lane skew. It then re-serialises the words in strict lane order 0,1,…,NUM_LANES-1 onto one output stream with a valid/ready handshake. It sits between the per-lane receive logic (deserialisers) and the PHY-to-link interface, and reports overflow and alignment errors.

---
 rtl/phy_pkg.sv | 24 ++
 rtl/byte_unstriping_n_lane_fifo.sv | 48 ++++
 rtl/byte_unstriping_n.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY receive-path types and constants: unstriper state encoding,
// default lane geometry and the error-counter width with its saturating adder.
package phy_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } unstripe_state_t;

  localparam int PHY_DATA_W    = 32;
  localparam int PHY_NUM_LANES = 2;
  localparam int ERR_CNT_W     = 16;

  // Adds b to a and clamps at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_add(
    input logic [ERR_CNT_W-1:0] a,
    input logic [ERR_CNT_W-1:0] b
  );
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/byte_unstriping_n_lane_fifo.sv
// Per-lane skew FIFO with a read-ahead head word (dout is valid whenever empty=0).
// A push into a full FIFO is accepted only when a pop retires the head on the same edge.
module lane_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_f) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_f) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/byte_unstriping_n.sv
// N-lane unstriper: per-lane skew FIFOs re-serialised in lane order 0..N-1 onto
// one valid/ready stream. Optional err_count output under `UNSTRIPE_ERR_CNT_EN.
module byte_unstriping_n
  import phy_pkg::*;
#(
  parameter int NUM_LANES  = PHY_NUM_LANES,
  parameter int DATA_W     = PHY_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_f,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        valid_in,
  input  logic [NUM_LANES*DATA_W-1:0] lane_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        lane_overflow,
  output logic                        align_err
`ifdef UNSTRIPE_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]        err_count
`endif
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  unstripe_state_t    state_reg, state_next;
  logic [LANE_W-1:0]  next_lane_reg, next_lane_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               valid_reg, valid_next;
  logic               align_reg, align_next;
  logic [NUM_LANES-1:0] overflow_reg;

  logic [NUM_LANES-1:0] fifo_push;
  logic [NUM_LANES-1:0] fifo_pop;
  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] fifo_full;
  logic [NUM_LANES-1:0] drop;
  logic [DATA_W-1:0]    fifo_dout [NUM_LANES];

  logic              pop_any;
  logic              flush;
  logic              head_empty;
  logic              other_full;
  logic              all_empty;
  logic [DATA_W-1:0] head;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign fifo_pop[gi]  = pop_any && (next_lane_reg == LANE_W'(gi));
      assign fifo_push[gi] = valid_in[gi] & ~flush;
      // A flushed word is discarded silently; only a genuine full-FIFO loss counts.
      assign drop[gi]      = valid_in[gi] & ~flush & fifo_full[gi] & ~fifo_pop[gi];

      lane_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk_f (clk_f),
        .reset (reset),
        .push  (fifo_push[gi]),
        .pop   (fifo_pop[gi]),
        .flush (flush),
        .din   (lane_in[gi*DATA_W +: DATA_W]),
        .dout  (fifo_dout[gi]),
        .empty (fifo_empty[gi]),
        .full  (fifo_full[gi])
      );
    end
  endgenerate

  assign all_empty = &fifo_empty;

  always_comb begin
    head       = '0;
    head_empty = 1'b1;
    other_full = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (next_lane_reg == LANE_W'(i)) begin
        head       = fifo_dout[i];
        head_empty = fifo_empty[i];
      end else if (fifo_full[i]) begin
        other_full = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    next_lane_next = next_lane_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    align_next     = 1'b0;
    pop_any        = 1'b0;
    flush          = 1'b0;

    case (state_reg)
      SYNC: begin
        // next_lane is always 0 here, so head is FIFO 0.
        pop_any = ~head_empty & (~valid_reg | out_ready);
        if (pop_any) state_next = RUN;
      end
      RUN: begin
        if ((next_lane_reg == '0) && all_empty) begin
          state_next = SYNC;
        end else if (head_empty && other_full) begin
          flush          = 1'b1;
          align_next     = 1'b1;
          next_lane_next = '0;
          state_next     = SYNC;
        end else begin
          pop_any = ~head_empty & (~valid_reg | out_ready);
        end
      end
      default: state_next = SYNC;
    endcase

    // The registered output word survives a flush until it is accepted.
    if (pop_any) begin
      data_next      = head;
      valid_next     = 1'b1;
      next_lane_next = (next_lane_reg == LAST_LANE) ? '0 : next_lane_reg + 1'b1;
    end else if (out_ready) begin
      data_next  = '0;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_reg     <= SYNC;
      next_lane_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      align_reg     <= 1'b0;
      overflow_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      next_lane_reg <= next_lane_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      align_reg     <= align_next;
      overflow_reg  <= overflow_reg | drop;
    end
  end

  assign data_out      = data_reg;
  assign valid_out     = valid_reg;
  assign align_err     = align_reg;
  assign lane_overflow = overflow_reg;

`ifdef UNSTRIPE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_reg;
  logic [ERR_CNT_W-1:0] err_inc;

  // Several lanes may drop on the same edge, so the increment is a population count.
  assign err_inc = ERR_CNT_W'($countones(drop)) + {{(ERR_CNT_W-1){1'b0}}, align_next};

  always_ff @(posedge clk_f) begin
    if (reset) begin
      err_count_reg <= '0;
    end else begin
      err_count_reg <= sat_add(err_count_reg, err_inc);
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule
